// File: rtl/cgra_trace_pkg.sv
// Shared types and default sizing for the CGRA input-side trace collector.
package cgra_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } trace_state_e;

    localparam int LANES_DEF  = 16;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int MON_W      = DATA_W_DEF + 1;

endpackage

// File: rtl/cgra_trace_lane_fifo.sv
// One lane of trace buffering: a DEPTH-entry FIFO with synchronous clear,
// where a push into a full FIFO is accepted only if a pop happens in the same cycle.
module cgra_trace_lane_fifo
    import cgra_trace_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the occupancy counter alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cgra_trace_collector.sv
// Taps the CGRA input lanes, buffers accepted beats per lane and releases one
// monitor frame per host step. Optional cycle stamp on steps: CGRA_TRACE_TS_EN.
module cgra_trace_collector
    import cgra_trace_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable_i,
    input  logic                         flush_i,
    input  logic                         step_i,
    input  logic [LANES-1:0]             tap_valid_i,
    input  logic [LANES-1:0]             tap_ready_i,
    input  logic [LANES*DATA_W-1:0]      tap_data_i,
    output logic [LANES*(DATA_W+1)-1:0]  ins_o,
    output logic [LANES-1:0]             overflow_o,
    output logic [1:0]                   state_o
`ifdef CGRA_TRACE_TS_EN
    ,
    output logic [31:0]                  step_cycle_o
`endif
);

    localparam int WORD_W = DATA_W + 1;

    trace_state_e state_q;

    logic                     capture_en;
    logic                     step_en;
    logic                     flush_now;
    logic [LANES-1:0]         push;
    logic [LANES-1:0]         full;
    logic [LANES-1:0]         empty;
    logic [LANES-1:0]         drop;
    logic [DATA_W-1:0]        head [LANES];
    logic [LANES*WORD_W-1:0]  ins_q, ins_d;
    logic [LANES-1:0]         overflow_q, overflow_d;

    assign capture_en = (state_q == RUN);
    assign step_en    = step_i && (state_q != FLUSH);
    assign flush_now  = (state_q == FLUSH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (flush_i) state_q <= FLUSH;
                         else if (enable_i) state_q <= RUN;
                RUN:     if (flush_i) state_q <= FLUSH;
                         else if (!enable_i) state_q <= IDLE;
                FLUSH:   state_q <= enable_i ? RUN : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign push[k] = capture_en && tap_valid_i[k] && tap_ready_i[k];
        // A full lane is never empty, so a step always frees the slot for the push.
        assign drop[k] = push[k] && full[k] && !step_en;

        cgra_trace_lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .push_i  (push[k]),
            .pop_i   (step_en),
            .clear_i (flush_now),
            .data_i  (tap_data_i[k*DATA_W +: DATA_W]),
            .full_o  (full[k]),
            .empty_o (empty[k]),
            .head_o  (head[k])
        );
    end

    always_comb begin
        ins_d      = ins_q;
        overflow_d = overflow_q | drop;
        if (flush_now) begin
            ins_d      = '0;
            overflow_d = '0;
        end else if (step_en) begin
            for (int k = 0; k < LANES; k++) begin
                ins_d[k*WORD_W +: WORD_W] = empty[k] ? '0 : {1'b1, head[k]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ins_q      <= '0;
            overflow_q <= '0;
        end else begin
            ins_q      <= ins_d;
            overflow_q <= overflow_d;
        end
    end

    assign ins_o      = ins_q;
    assign overflow_o = overflow_q;
    assign state_o    = state_q;

`ifdef CGRA_TRACE_TS_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] step_cycle_q, step_cycle_d;

    // The counter ignores flush; only reset_n restarts it.
    always_comb begin
        cycle_d      = cycle_q + 32'd1;
        step_cycle_d = step_en ? cycle_q : step_cycle_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q      <= '0;
            step_cycle_q <= '0;
        end else begin
            cycle_q      <= cycle_d;
            step_cycle_q <= step_cycle_d;
        end
    end

    assign step_cycle_o = step_cycle_q;
`endif

endmodule

// File: tb/tb_cgra_trace_collector.sv
// Bench for cgra_trace_collector: per-lane reference queues act as the scoreboard,
// a vector table walks the FSM, and hand sequences cover overflow, bypass, flush and reset.
module tb_cgra_trace_collector;
    import cgra_trace_pkg::*;

    localparam int LANES  = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int WORD_W = DATA_W + 1;

    logic                        clock;
    logic                        reset_n;
    logic                        enable_i;
    logic                        flush_i;
    logic                        step_i;
    logic [LANES-1:0]            tap_valid_i;
    logic [LANES-1:0]            tap_ready_i;
    logic [LANES*DATA_W-1:0]     tap_data_i;
    logic [LANES*WORD_W-1:0]     ins_o;
    logic [LANES-1:0]            overflow_o;
    logic [1:0]                  state_o;
`ifdef CGRA_TRACE_TS_EN
    logic [31:0]                 step_cycle_o;
`endif

    cgra_trace_collector #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable_i    (enable_i),
        .flush_i     (flush_i),
        .step_i      (step_i),
        .tap_valid_i (tap_valid_i),
        .tap_ready_i (tap_ready_i),
        .tap_data_i  (tap_data_i),
        .ins_o       (ins_o),
        .overflow_o  (overflow_o),
        .state_o     (state_o)
`ifdef CGRA_TRACE_TS_EN
        ,
        .step_cycle_o (step_cycle_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected FIFO contents, monitor words, sticky flags, state.
    logic [DATA_W-1:0] mq [LANES][$];
    logic [WORD_W-1:0] exp_ins [LANES];
    logic [LANES-1:0]  exp_ovf;
    trace_state_e      m_state;

    typedef struct {
        logic        en;
        logic        fl;
        logic        st;
        logic [15:0] vm;
        logic [15:0] rm;
        logic [31:0] base;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] lane_word(input int k);
        return ins_o[k*WORD_W +: WORD_W];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            mq[k].delete();
            exp_ins[k] = '0;
        end
        exp_ovf = '0;
        m_state = IDLE;
    endtask

    task automatic fire(input int lane, input logic [DATA_W-1:0] data);
        tap_valid_i[lane] = 1'b1;
        tap_ready_i[lane] = 1'b1;
        tap_data_i[lane*DATA_W +: DATA_W] = data;
    endtask

    // Apply one cycle of control + current taps, update the model, then compare after the edge.
    task automatic tick(input logic en, input logic fl, input logic st);
        logic step_ok;
        logic pop;
        logic push;
        logic acc;
        enable_i = en;
        flush_i  = fl;
        step_i   = st;
        step_ok  = st && (m_state != FLUSH);
        for (int k = 0; k < LANES; k++) begin
            if (m_state == FLUSH) begin
                mq[k].delete();
                exp_ins[k] = '0;
                exp_ovf[k] = 1'b0;
            end else begin
                pop  = step_ok && (mq[k].size() > 0);
                push = (m_state == RUN) && tap_valid_i[k] && tap_ready_i[k];
                acc  = push && ((mq[k].size() < DEPTH) || pop);
                if (step_ok) exp_ins[k] = pop ? {1'b1, mq[k][0]} : '0;
                if (pop) void'(mq[k].pop_front());
                if (acc) mq[k].push_back(tap_data_i[k*DATA_W +: DATA_W]);
                else if (push) exp_ovf[k] = 1'b1;
            end
        end
        case (m_state)
            IDLE:    m_state = fl ? FLUSH : (en ? RUN : IDLE);
            RUN:     m_state = fl ? FLUSH : (en ? RUN : IDLE);
            default: m_state = en ? RUN : IDLE;
        endcase
        @(posedge clock);
        #1;
        tap_valid_i = '0;
        tap_ready_i = '0;
        tap_data_i  = '0;
        for (int k = 0; k < LANES; k++) begin
            check($sformatf("ins lane %0d", k), 64'(lane_word(k)), 64'(exp_ins[k]));
        end
        check("overflow_o", 64'(overflow_o), 64'(exp_ovf));
        check("state_o", 64'(state_o), 64'(m_state));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'h100, 2'd1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h00FF, 32'h200, 2'd1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0F0F, 16'hFFFF, 32'h300, 2'd1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 32'h000, 2'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'h400, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h500, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h000, 2'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'hAAAA, 16'hFFFF, 32'h600, 2'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'hAAAA, 16'hFFFF, 32'h700, 2'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h5555, 16'h5555, 32'h800, 2'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h900, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 32'h000, 2'd0};

        reset_n     = 1'b0;
        enable_i    = 1'b0;
        flush_i     = 1'b0;
        step_i      = 1'b0;
        tap_valid_i = '0;
        tap_ready_i = '0;
        tap_data_i  = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset ins_o any bit", 64'(|ins_o), 64'd0);
        check("reset overflow_o", 64'(overflow_o), 64'd0);
        check("reset state_o", 64'(state_o), 64'd0);
        reset_n = 1'b1;

        // Single beat on lane 3 reaches the monitor on the next step.
        tick(1'b1, 1'b0, 1'b0);
        fire(3, 32'hDEADBEEF);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("lane3 beat", 64'(lane_word(3)), 64'h1_DEADBEEF);
        check("lane0 idle", 64'(lane_word(0)), 64'h0);
        check("state run", 64'(state_o), 64'd1);

        // Lane 0 overflow: the fifth beat is dropped.
        for (int i = 1; i <= 5; i++) begin
            fire(0, 32'(i));
            tick(1'b1, 1'b0, 1'b0);
        end
        check("lane0 overflow flag", 64'(overflow_o[0]), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            check($sformatf("lane0 drain %0d", i), 64'(lane_word(0)), 64'h1_0000_0000 | 64'(i));
        end
        tick(1'b1, 1'b0, 1'b1);
        check("lane0 drained empty", 64'(lane_word(0)), 64'h0);

        // No bypass: push and step together on an empty lane.
        fire(7, 32'hA5);
        tick(1'b1, 1'b0, 1'b1);
        check("lane7 no bypass", 64'(lane_word(7)), 64'h0);
        tick(1'b1, 1'b0, 1'b1);
        check("lane7 next step", 64'(lane_word(7)), 64'h1_0000_00A5);

        // Full lane with a same-cycle pop accepts the push.
        for (int i = 0; i < 4; i++) begin
            fire(9, 32'h90 + 32'(i));
            tick(1'b1, 1'b0, 1'b0);
        end
        fire(9, 32'h94);
        tick(1'b1, 1'b0, 1'b1);
        check("lane9 full+pop head", 64'(lane_word(9)), 64'h1_0000_0090);
        check("lane9 no overflow", 64'(overflow_o[9]), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            check($sformatf("lane9 drain %0d", i), 64'(lane_word(9)), 64'h1_0000_0090 + 64'(i));
        end

        // Flush with lane 2 holding three entries; step during FLUSH is ignored.
        for (int i = 1; i <= 3; i++) begin
            fire(2, 32'h20 + 32'(i));
            tick(1'b1, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b1, 1'b0);
        check("state flush", 64'(state_o), 64'd2);
        tick(1'b1, 1'b0, 1'b1);
        check("state after flush", 64'(state_o), 64'd1);
        check("flush ins_o any bit", 64'(|ins_o), 64'd0);
        check("flush overflow_o", 64'(overflow_o), 64'd0);
        tick(1'b1, 1'b0, 1'b1);
        check("lane2 after flush", 64'(lane_word(2)), 64'h0);

        // IDLE ignores taps but still drains earlier entries.
        fire(5, 32'h11);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("state idle", 64'(state_o), 64'd0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < LANES; k++) fire(k, 32'hF0 + 32'(k));
            tick(1'b0, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b1);
        check("lane5 drained in idle", 64'(lane_word(5)), 64'h1_0000_0011);
        check("lane0 idle ignored", 64'(lane_word(0)), 64'h0);
        tick(1'b0, 1'b0, 1'b1);
        check("lane5 empty after idle", 64'(lane_word(5)), 64'h0);

        // Vector table walks the FSM; ins/overflow come from the model.
        for (int i = 0; i < 12; i++) begin
            tap_valid_i = vecs[i].vm;
            tap_ready_i = vecs[i].rm;
            for (int k = 0; k < LANES; k++) tap_data_i[k*DATA_W +: DATA_W] = vecs[i].base + 32'(k);
            tick(vecs[i].en, vecs[i].fl, vecs[i].st);
            check($sformatf("table row %0d state", i), 64'(state_o), 64'(vecs[i].exp_state));
        end

        // Asynchronous reset with buffered entries.
        tick(1'b1, 1'b0, 1'b0);
        fire(1, 32'hC1);
        fire(4, 32'hC4);
        tick(1'b1, 1'b0, 1'b0);
        fire(1, 32'hC2);
        tick(1'b1, 1'b0, 1'b1);
        check("pre-reset lane1", 64'(lane_word(1)), 64'h1_0000_00C1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset ins_o any bit", 64'(|ins_o), 64'd0);
        check("async reset overflow_o", 64'(overflow_o), 64'd0);
        check("async reset state_o", 64'(state_o), 64'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        check("post-reset ins_o any bit", 64'(|ins_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cgra_trace_collector.md
Name: cgra_trace_collector

Overview:
- Upstream feeder for the CGRA input-side DPI-C trace monitor.
- Passively taps the 16 CGRA input lanes and records every accepted transaction (valid & ready) in a per-lane FIFO.
- Presents one 33-bit {valid, data} word per lane to the monitor, advancing only when the difftest host issues a step.
- Decouples CGRA-rate traffic from the slower, host-paced comparison.

Parameters:
- LANES, 16, number of tapped CGRA input lanes.
- DATA_W, 32, data width per lane; monitor word is DATA_W+1 bits.
- DEPTH, 4, per-lane FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  capture enable.
- flush_i  in  1  one-cycle request to discard all buffered trace.
- step_i  in  1  host step: load next monitor frame.
- tap_valid_i  in  LANES  CGRA lane valid.
- tap_ready_i  in  LANES  CGRA lane ready.
- tap_data_i  in  LANES*DATA_W  lane k data at bits [k*DATA_W +: DATA_W].
- ins_o  out  LANES*(DATA_W+1)  lane k word at [k*(DATA_W+1) +: DATA_W+1]; MSB = valid. Feeds monitor ins_0..ins_15.
- overflow_o  out  LANES  sticky per-lane drop flag.
- state_o  out  2  FSM state encoding.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FIFOs empty.
  - ins_o all zero.
  - overflow_o zero.
  - State IDLE (state_o = 0).
- FSM (RUN = 1, FLUSH = 2):
  - IDLE -> RUN when enable_i = 1.
  - RUN -> FLUSH when flush_i = 1. Flush has priority over enable_i = 0.
  - RUN -> IDLE when enable_i = 0 and flush_i = 0.
  - IDLE -> FLUSH when flush_i = 1.
  - FLUSH lasts exactly one cycle, then goes to RUN if enable_i = 1, else IDLE.
- Capture:
  - In RUN only, lane k pushes tap_data_i[k] on a clock edge where tap_valid_i[k] & tap_ready_i[k].
  - Taps are ignored in IDLE and FLUSH.
  - Pure observer: never drives back into the CGRA.
- Step:
  - Honoured in IDLE and RUN, ignored in FLUSH.
  - On a step edge, every lane loads ins_o: FIFO non-empty -> {1, head} and pop; empty -> {1'b0, 0}.
  - ins_o holds between steps.
- Latency:
  - A transaction captured at edge t is visible on ins_o no earlier than the step edge at t+1.
  - No bypass: push and step on an empty lane in the same cycle outputs invalid and stores the entry.
- Simultaneous push and pop on one lane: both occur; occupancy unchanged.
- Full lane:
  - Push without a same-cycle pop drops the new data and sets overflow_o[k].
  - Push with a same-cycle pop is accepted.
- FLUSH cycle:
  - Empties all FIFOs.
  - Clears every ins_o valid bit and data.
  - Clears overflow_o.
- Pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits so full and empty are distinct.
- Lanes are fully independent; no cross-lane ordering is implied.

Optional Feature:
- Macro CGRA_TRACE_TS_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, reset to 0 by reset_n only, wrapping at 2^32.
  - Adds output step_cycle_o (32 bits), loaded with the counter value on every honoured step.
  - step_cycle_o resets to 0.
- Undefined: counter and port are absent.

Decomposition:
- Package cgra_trace_pkg holds:
  - State enum: IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2.
  - Defaults LANES_DEF = 16, DATA_W_DEF = 32, DEPTH_DEF = 4.
  - Monitor word width constant MON_W = DATA_W_DEF + 1.
- Sub-module cgra_trace_lane_fifo: one lane's FIFO with push, pop, clear, full, empty and head; instantiated LANES times in a generate loop.

Test Plan:
- Reset, enable_i = 1, lane 3 fires 0xDEADBEEF, step next cycle -> ins_o lane 3 = 0x1_DEADBEEF, all other lanes 0x0_00000000, state_o = 1.
- Lane 0 fires 0x1, 0x2, 0x3, 0x4, 0x5 with no step -> overflow_o[0] = 1; four steps yield 0x1..0x4 valid; fifth step yields invalid.
- Lane 7 empty, fire 0xA5 and step in the same cycle -> that step shows lane 7 invalid; next step shows 0x1_000000A5.
- Lane 2 holding three entries, flush_i pulse -> state sequence RUN, FLUSH, RUN; ins_o all zero; overflow_o zero; following step shows lane 2 invalid.
- enable_i = 0 (IDLE) while lanes fire -> nothing captured; a step still drains 0x11 stored earlier on lane 5.
- reset_n asserted mid-stream with entries buffered -> outputs zero immediately, without waiting for a clock edge; after release, a step shows all lanes invalid.
